projectile_ctrl: RTL and testbench

Player projectile controller for the VGA shooter. It launches a single projectile from the ship on a fire-button press and advances it upward once per video frame. It retires the projectile when it leaves the playfield or when the enemy block reports a hit. Its `projectile_h`/`projectile_v` outputs drive the enemy hit detector directly, and it consumes that block's `hit` output.

---
 rtl/projectile_ctrl_pkg.sv | 25 ++
 rtl/projectile_ctrl_rise_detect.sv | 19 +
 rtl/projectile_ctrl.sv | 133 +++++++++++++
 tb/tb_projectile_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/projectile_ctrl_pkg.sv
// Shared game definitions: screen geometry, parked coordinate and FSM state encodings.
package projectile_ctrl_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_TOP_DEF = 35;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned SHOTS_W   = 8;

    // Off-screen coordinate, well outside any enemy hit window.
    localparam logic [COORD_W-1:0] PARK = 10'd1023;

    // One-hot projectile states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_FLIGHT = 3'b010,
        ST_COOL   = 3'b100
    } state_e;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/projectile_ctrl_rise_detect.sv
// Registered rising-edge detector for synchronised button levels.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic in_q;

    // Remember last cycle's level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) in_q <= 1'b0;
        else       in_q <= in;
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/projectile_ctrl.sv
// Player projectile: launch from the ship, climb once per frame, retire on exit or hit.
module projectile_ctrl
    import projectile_ctrl_pkg::*;
#(
    parameter int unsigned SPEED      = 4,
    parameter int unsigned V_TOP      = V_TOP_DEF,
    parameter int unsigned LAUNCH_OFS = 10,
    parameter int unsigned COOLDOWN   = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               fire,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] ship_h,
    input  logic [COORD_W-1:0] ship_v,
    input  logic               hit,
    output logic [COORD_W-1:0] projectile_h,
    output logic [COORD_W-1:0] projectile_v,
    output logic               active,
    output logic [SHOTS_W-1:0] shots
);

    localparam int unsigned CNT_W = cnt_width(COOLDOWN);
    localparam logic [COORD_W-1:0] LAUNCH_MIN   = COORD_W'(V_TOP + LAUNCH_OFS);
    localparam logic [COORD_W-1:0] RETIRE_BELOW = COORD_W'(V_TOP + SPEED);
    localparam logic [COORD_W-1:0] STEP         = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] OFS          = COORD_W'(LAUNCH_OFS);
    localparam logic [CNT_W-1:0]   CNT_LOAD     = CNT_W'(COOLDOWN);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic               active_q, active_d;
    logic [SHOTS_W-1:0] shots_q, shots_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fire_rise;
    logic               fire_gated;
    logic               retire;

    // Masking fire during start leaves the edge register cleared.
    assign fire_gated = fire & ~start;

    rise_detect u_fire_rise (
        .clk   (clk),
        .reset (reset),
        .in    (fire_gated),
        .rise  (fire_rise)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            h_q      <= PARK;
            v_q      <= PARK;
            active_q <= 1'b0;
            shots_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            active_q <= active_d;
            shots_q  <= shots_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: start overrides everything; hit beats frame_tick in flight.
    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        v_d      = v_q;
        active_d = active_q;
        shots_d  = shots_q;
        cnt_d    = cnt_q;
        retire   = 1'b0;

        if (start) begin
            state_d  = ST_IDLE;
            h_d      = PARK;
            v_d      = PARK;
            active_d = 1'b0;
            shots_d  = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fire_rise && (ship_v >= LAUNCH_MIN)) begin
                        state_d  = ST_FLIGHT;
                        h_d      = ship_h;
                        v_d      = ship_v - OFS;
                        active_d = 1'b1;
                        if (shots_q != {SHOTS_W{1'b1}}) shots_d = shots_q + SHOTS_W'(1);
                    end
                end
                ST_FLIGHT: begin
                    if (hit) begin
                        retire = 1'b1;
                    end else if (frame_tick) begin
                        if (v_q < RETIRE_BELOW) retire = 1'b1;
                        else                    v_d = v_q - STEP;
                    end
                end
                ST_COOL: begin
                    if (cnt_q == '0)     state_d = ST_IDLE;
                    else if (frame_tick) cnt_d = cnt_q - CNT_W'(1);
                end
                default: begin
                    state_d  = ST_IDLE;
                    h_d      = PARK;
                    v_d      = PARK;
                    active_d = 1'b0;
                    cnt_d    = '0;
                end
            endcase

            if (retire) begin
                state_d  = ST_COOL;
                h_d      = PARK;
                v_d      = PARK;
                active_d = 1'b0;
                cnt_d    = CNT_LOAD;
            end
        end
    end

    assign projectile_h = h_q;
    assign projectile_v = v_q;
    assign active       = active_q;
    assign shots        = shots_q;

endmodule

// File: tb/tb_projectile_ctrl.sv
// Self-checking bench for projectile_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_projectile_ctrl;

    localparam int SPEED = 4;
    localparam int V_TOP = 35;
    localparam int LOFS  = 10;
    localparam int COOL  = 15;

    logic       clk = 1'b0;
    logic       reset, start, fire, frame_tick, hit;
    logic [9:0] ship_h, ship_v;
    logic [9:0] projectile_h, projectile_v;
    logic       active;
    logic [7:0] shots;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: mode 0 = waiting, 1 = flying, 2 = cooling down.
    int m_mode, m_h, m_v, m_act, m_shots, m_cnt, m_pf;

    always #5 clk = ~clk;

    projectile_ctrl #(
        .SPEED(SPEED), .V_TOP(V_TOP), .LAUNCH_OFS(LOFS), .COOLDOWN(COOL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .fire         (fire),
        .frame_tick   (frame_tick),
        .ship_h       (ship_h),
        .ship_v       (ship_v),
        .hit          (hit),
        .projectile_h (projectile_h),
        .projectile_v (projectile_v),
        .active       (active),
        .shots        (shots)
    );

    function automatic logic [28:0] exp_vec();
        return {10'(m_h), 10'(m_v), 1'(m_act), 8'(m_shots)};
    endfunction

    task automatic m_clear();
        m_mode = 0; m_h = 1023; m_v = 1023; m_act = 0; m_shots = 0; m_cnt = 0; m_pf = 0;
    endtask

    task automatic m_retire();
        m_mode = 2; m_h = 1023; m_v = 1023; m_act = 0; m_cnt = COOL;
    endtask

    // Apply one clock's worth of the game rules to the model.
    task automatic m_step();
        int rise;
        rise = (fire && !m_pf) ? 1 : 0;
        if (start) begin
            m_clear();
            return;
        end
        m_pf = fire ? 1 : 0;
        if (m_mode == 0) begin
            if (rise == 1 && int'(ship_v) >= V_TOP + LOFS) begin
                m_mode = 1; m_h = int'(ship_h); m_v = int'(ship_v) - LOFS; m_act = 1;
                if (m_shots < 255) m_shots++;
            end
        end else if (m_mode == 1) begin
            if (hit) m_retire();
            else if (frame_tick) begin
                if (m_v < V_TOP + SPEED) m_retire();
                else m_v = m_v - SPEED;
            end
        end else begin
            if (m_cnt == 0) m_mode = 0;
            else if (frame_tick) m_cnt--;
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic tick_gap();
        frame_tick = 1'b1; step();
        frame_tick = 1'b0; step();
    endtask

    task automatic pulse_fire();
        fire = 1'b1; step();
        fire = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; fire = 1'b0; frame_tick = 1'b0; hit = 1'b0;
        ship_h = 10'd320; ship_v = 10'd450;
        m_clear();
        #23;
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== {10'd1023, 10'd1023, 1'b0, 8'd0})
            $display("FAIL reset_state: got %h want %h", {projectile_h, projectile_v, active, shots},
                     {10'd1023, 10'd1023, 1'b0, 8'd0});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        step();
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== exp_vec())
            $display("FAIL reset_release: got %h want %h", {projectile_h, projectile_v, active, shots}, exp_vec());
        else n_pass++;
    endtask

    task automatic test_launch();
        pulse_fire();
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== {10'd320, 10'd440, 1'b1, 8'd1})
            $display("FAIL launch: got %h want %h", {projectile_h, projectile_v, active, shots},
                     {10'd320, 10'd440, 1'b1, 8'd1});
        else n_pass++;
    endtask

    task automatic test_flight_top();
        for (int i = 0; i < 101; i++) tick_gap();
        n_total++;
        if ({projectile_v, active} !== {10'd36, 1'b1})
            $display("FAIL flight_101: got v=%0d act=%0d want v=36 act=1", projectile_v, active);
        else n_pass++;
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== {10'd1023, 10'd1023, 1'b0, 8'd1})
            $display("FAIL flight_exit: got %h want %h", {projectile_h, projectile_v, active, shots},
                     {10'd1023, 10'd1023, 1'b0, 8'd1});
        else n_pass++;
        for (int i = 0; i < 14; i++) tick_gap();
        pulse_fire(); step();
        n_total++;
        if ({active, shots} !== {1'b0, 8'd1})
            $display("FAIL cooldown_fire_ignored: got act=%0d shots=%0d want act=0 shots=1", active, shots);
        else n_pass++;
        tick_gap();
        pulse_fire();
        n_total++;
        if ({projectile_v, active, shots} !== {10'd440, 1'b1, 8'd2})
            $display("FAIL rearm_launch: got v=%0d act=%0d shots=%0d want v=440 act=1 shots=2",
                     projectile_v, active, shots);
        else n_pass++;
    endtask

    task automatic test_hit();
        for (int i = 0; i < 60; i++) tick_gap();
        n_total++;
        if (projectile_v !== 10'd200)
            $display("FAIL hit_setup: got v=%0d want v=200", projectile_v);
        else n_pass++;
        hit = 1'b1; frame_tick = 1'b1; step();
        hit = 1'b0; frame_tick = 1'b0;
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== {10'd1023, 10'd1023, 1'b0, 8'd2})
            $display("FAIL hit_retire: got %h want %h", {projectile_h, projectile_v, active, shots},
                     {10'd1023, 10'd1023, 1'b0, 8'd2});
        else n_pass++;
        hit = 1'b1; pulse_fire(); hit = 1'b0; step();
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== exp_vec() || shots !== 8'd2)
            $display("FAIL hit_in_cooldown: got %h want %h", {projectile_h, projectile_v, active, shots}, exp_vec());
        else n_pass++;
        for (int i = 0; i < COOL; i++) tick_gap();
    endtask

    task automatic test_fire_hold();
        do_start();
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== {10'd1023, 10'd1023, 1'b0, 8'd0})
            $display("FAIL start_clear: got %h want %h", {projectile_h, projectile_v, active, shots},
                     {10'd1023, 10'd1023, 1'b0, 8'd0});
        else n_pass++;
        fire = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            step();
        end
        fire = 1'b0; frame_tick = 1'b0; step();
        n_total++;
        if (shots !== 8'd1 || {projectile_h, projectile_v, active, shots} !== exp_vec())
            $display("FAIL fire_hold: got shots=%0d act=%0d want shots=1 act=%0d", shots, active, m_act);
        else n_pass++;
        do_start();
        pulse_fire(); step();
        pulse_fire(); step();
        n_total++;
        if ({active, shots} !== {1'b1, 8'd1})
            $display("FAIL second_press: got act=%0d shots=%0d want act=1 shots=1", active, shots);
        else n_pass++;
    endtask

    task automatic test_saturate();
        do_start();
        for (int i = 0; i < 260; i++) begin
            pulse_fire();
            hit = 1'b1; step(); hit = 1'b0;
            for (int k = 0; k < COOL; k++) tick_gap();
        end
        n_total++;
        if (shots !== 8'd255 || {projectile_h, projectile_v, active, shots} !== exp_vec())
            $display("FAIL shots_saturate: got shots=%0d want 255", shots);
        else n_pass++;
    endtask

    task automatic test_start_reject();
        do_start();
        pulse_fire();
        for (int i = 0; i < 35; i++) tick_gap();
        n_total++;
        if (projectile_v !== 10'd300)
            $display("FAIL start_setup: got v=%0d want v=300", projectile_v);
        else n_pass++;
        do_start();
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== {10'd1023, 10'd1023, 1'b0, 8'd0})
            $display("FAIL start_midflight: got %h want %h", {projectile_h, projectile_v, active, shots},
                     {10'd1023, 10'd1023, 1'b0, 8'd0});
        else n_pass++;
        pulse_fire();
        n_total++;
        if ({projectile_v, active, shots} !== {10'd440, 1'b1, 8'd1})
            $display("FAIL start_then_fire: got v=%0d act=%0d shots=%0d want v=440 act=1 shots=1",
                     projectile_v, active, shots);
        else n_pass++;
        do_start();
        ship_v = 10'd40;
        pulse_fire(); step();
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== {10'd1023, 10'd1023, 1'b0, 8'd0})
            $display("FAIL launch_reject: got %h want %h", {projectile_h, projectile_v, active, shots},
                     {10'd1023, 10'd1023, 1'b0, 8'd0});
        else n_pass++;
        ship_v = 10'd45;
        pulse_fire();
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== {10'd320, 10'd35, 1'b1, 8'd1})
            $display("FAIL launch_edge: got %h want %h", {projectile_h, projectile_v, active, shots},
                     {10'd320, 10'd35, 1'b1, 8'd1});
        else n_pass++;
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_total++;
        if ({projectile_v, active} !== {10'd1023, 1'b0})
            $display("FAIL exit_from_top_row: got v=%0d act=%0d want v=1023 act=0", projectile_v, active);
        else n_pass++;
        ship_v = 10'd450;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) tick_gap();
        #2;
        reset = 1'b1;
        m_clear();
        #1;
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== {10'd1023, 10'd1023, 1'b0, 8'd0})
            $display("FAIL async_reset: got %h want %h", {projectile_h, projectile_v, active, shots},
                     {10'd1023, 10'd1023, 1'b0, 8'd0});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        pulse_fire();
        n_total++;
        if ({projectile_h, projectile_v, active, shots} !== exp_vec() || active !== 1'b1)
            $display("FAIL after_async_reset: got %h want %h", {projectile_h, projectile_v, active, shots}, exp_vec());
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) fire = ~fire;
            frame_tick = ($urandom_range(0, 2) == 0);
            hit        = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) begin
                ship_v = 10'($urandom_range(0, 479));
                ship_h = 10'($urandom_range(0, 639));
            end
            step();
            n_total++;
            if ({projectile_h, projectile_v, active, shots} !== exp_vec()) begin
                if (errs < 10)
                    $display("FAIL random_cycle_%0d: got %h want %h", i,
                             {projectile_h, projectile_v, active, shots}, exp_vec());
                errs++;
            end else n_pass++;
        end
        start = 1'b0; fire = 1'b0; frame_tick = 1'b0; hit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_launch();
        test_flight_top();
        test_hit();
        test_fire_hold();
        test_saturate();
        test_start_reject();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
